ballot_unit: RTL
================

// Module: ballot_unit
// PURPOSE
//  Voter-side ballot unit; the transmitting end of the vote-code link into the voting control unit.
//  - Arms on a Ballot issue pulse from the control unit.
//  - Debounces the candidate buttons and accepts exactly one press.
//  - Drives the 4-bit vote code on IN for a fixed number of cycles, then waits for all buttons to release.
//  - Keeps a local count of votes cast for cross-checking against the control unit's Total.
// PARAMETERS
//  NCAND     8    candidate buttons; legal range 1..14; codes 1..NCAND
//  DEB_CYC   3    cycles a single button must be stable before acceptance (>=1)
//  HOLD_CYC  2    cycles IN holds the code (>=1)
//  TMO_CYC   500  cycles in ARMED with no valid press before abandoning the ballot
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  Clear     in   1      reset, synchronous, active-high
//  Power     in   1      unit enable; low => behaves as Clear every cycle
//  Ballot    in   1      ballot issue from control unit, level; rising edge arms
//  Btn       in   NCAND  candidate buttons, active-high, asynchronous to clk
//  IN        out  4      vote code to control unit; 0 = no vote
//  Ready     out  1      ballot armed, voter may press
//  Busy      out  1      unit not IDLE
//  Invalid   out  1      1-cycle pulse: multi-press rejected
//  Timeout   out  1      1-cycle pulse: armed ballot expired unused
//  Cast      out  12     votes sent since Clear; saturates at 4095
// BEHAVIOUR
//  Reset and power-off:
//  - Clear=1 or Power=0: state=IDLE; IN, Ready, Busy, Invalid, Timeout and Cast all 0.
//  - Sync stages and debounce counters cleared.
//  - Applies mid-send: an IN code in flight is truncated to 0 next cycle.
//  Input conditioning:
//  - Btn passes through a 2-flop synchroniser.
//  - Ballot is registered; rise = Ballot & ~Ballot_q.
//  States:
//  - IDLE: rise -> ARMED. Ballot in any other state is ignored.
//  - ARMED: Ready=1, timer runs.
//    - Exactly one synced button high -> DEBOUNCE with idx latched.
//    - >1 high -> Invalid pulse; stay ARMED; timer not reset.
//    - Timer reaches TMO_CYC -> Timeout pulse, -> IDLE.
//  - DEBOUNCE: Ready=1.
//    - The same single button stays high for DEB_CYC consecutive cycles -> SEND.
//    - It drops, or any other button rises -> back to ARMED (Invalid pulse if >1 high).
//    - Timeout is checked in DEBOUNCE as in ARMED.
//  - SEND: IN=idx+1 for exactly HOLD_CYC cycles; first code cycle is the cycle after entry.
//    - Cast increments once, on SEND entry.
//    - Then -> RELEASE.
//  - RELEASE: IN=0; wait until all synced Btn are 0 -> IDLE. Buttons held forever => stuck here.
//  Flags:
//  - Busy = (state != IDLE).
//  - Ready = ARMED | DEBOUNCE.
//  - IN is registered and is 0 outside SEND.
//  Latency: button press to first IN code = 2 (sync) + DEB_CYC + 1 cycles = 6 at defaults.
//  Boundaries:
//  - Ballot rise on the same cycle IDLE is re-entered from RELEASE: honoured next cycle only if still the rise cycle. Not queued.
//  - Cast at 4095 stays 4095.
//  - NCAND > 14 is a configuration error: flag with an elaboration assertion.
// STRUCTURE
//  Shared package ballot_pkg:
//  - state enum {IDLE, ARMED, DEBOUNCE, SEND, RELEASE}.
//  - CODE_W=4, CODE_NONE=4'h0, CAST_W=12.
//  Sub-module btn_debounce:
//  - Contains the synchroniser, the one-hot/multi-hot detect and the stability counter.
//  - Outputs: single, multi, idx, stable.
//  Top level holds the FSM, timers, IN register and Cast counter.
// TESTING
//  1. Clear, Ballot rise, Btn[0] high 10 cycles -> IN=1 for 2 cycles starting 6 cycles after press; Cast=1; back to IDLE after release.
//  2. Ballot rise, Btn=8'b0001_0001 -> Invalid pulse, IN stays 0; then Btn=8'b0001_0000 -> IN=5 for 2 cycles.
//  3. Btn[2] glitch 2 cycles then low -> no IN; later a 5-cycle hold -> IN=3.
//  4. Ballot rise, no press for 500 cycles -> Timeout pulse, IDLE, Cast unchanged.
//  5. Ballot pulses while in SEND/RELEASE -> ignored, exactly one code sent; hold Btn -> stays RELEASE.
//  6. Clear asserted on 1st SEND cycle -> IN=0 next cycle, Cast=0; Power=0 -> all outputs 0 and Ballot ignored.

Source files
------------

// File: rtl/ballot_pkg.sv
// ballot_pkg: shared states and widths for the ballot unit
package ballot_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, DEBOUNCE, SEND, RELEASE} state_t;
  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] CODE_NONE = 4'h0;
  localparam int CAST_W = 12;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: button synchroniser, one-hot/multi-hot detect and stability counter
module btn_debounce #(
  parameter int NCAND = 8,
  parameter int DEB_CYC = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [NCAND-1:0] btn,
  output logic             single,
  output logic             multi,
  output logic [3:0]       idx,
  output logic             stable
);
  localparam int CW = $clog2(DEB_CYC + 1);
  logic [NCAND-1:0] s1, s2;
  logic [3:0] idx_q;
  logic [CW-1:0] run, eff;
  logic cont;
  always_ff @(posedge clk) begin
    if (clr) begin
      s1 <= '0;
      s2 <= '0;
      run <= '0;
      idx_q <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      run <= eff;
      idx_q <= idx;
    end
  end
  // run counts consecutive cycles the same lone button has been high, saturating at DEB_CYC
  always_comb begin
    multi = |(s2 & (s2 - NCAND'(1)));
    single = |s2 & ~multi;
    idx = '0;
    for (int i = 0; i < NCAND; i++)
      if (s2[i]) idx = 4'(i);
    cont = single & (run != '0) & (idx == idx_q);
    eff = !single ? '0 : !cont ? CW'(1) : (run == CW'(DEB_CYC)) ? run : run + CW'(1);
    stable = single & (eff == CW'(DEB_CYC));
  end
endmodule

// File: rtl/ballot_unit.sv
// ballot_unit: voter-side ballot unit driving a one-shot vote code to the control unit
module ballot_unit
  import ballot_pkg::*;
#(
  parameter int NCAND = 8,
  parameter int DEB_CYC = 3,
  parameter int HOLD_CYC = 2,
  parameter int TMO_CYC = 500
) (
  input  logic              clk,
  input  logic              Clear,
  input  logic              Power,
  input  logic              Ballot,
  input  logic [NCAND-1:0]  Btn,
  output logic [CODE_W-1:0] IN,
  output logic              Ready,
  output logic              Busy,
  output logic              Invalid,
  output logic              Timeout,
  output logic [CAST_W-1:0] Cast
);
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  if (NCAND < 1 || NCAND > 14) begin : g_bad_ncand
    $error("ballot_unit: NCAND must be 1..14");
  end
  state_t state, state_n;
  logic clr, ballot_q, rise, multi_q, inv_n, tmo_n, tmr_end;
  logic single, multi, stable;
  logic [3:0] idx;
  logic [CODE_W-1:0] sel;
  logic [TW-1:0] tmr;
  logic [HW-1:0] hold;
  assign clr = Clear | ~Power;
  assign rise = Ballot & ~ballot_q;
  assign tmr_end = tmr == TW'(TMO_CYC - 1);
  assign Ready = (state == ARMED) | (state == DEBOUNCE);
  assign Busy = state != IDLE;
  btn_debounce #(.NCAND(NCAND), .DEB_CYC(DEB_CYC)) u_deb (
    .clk(clk), .clr(clr), .btn(Btn),
    .single(single), .multi(multi), .idx(idx), .stable(stable)
  );
  always_comb begin
    state_n = state;
    inv_n = 1'b0;
    tmo_n = 1'b0;
    case (state)
      IDLE: state_n = rise ? ARMED : IDLE;
      ARMED: begin
        if (tmr_end) begin
          tmo_n = 1'b1;
          state_n = IDLE;
        end else if (multi) inv_n = ~multi_q;
        else if (single) state_n = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (tmr_end) begin
          tmo_n = 1'b1;
          state_n = IDLE;
        end else if (!single || idx != sel) begin
          inv_n = multi & ~multi_q;
          state_n = ARMED;
        end else if (stable) state_n = SEND;
      end
      SEND: state_n = (hold == HW'(HOLD_CYC - 1)) ? RELEASE : SEND;
      RELEASE: state_n = (single | multi) ? RELEASE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      ballot_q <= 1'b0;
      multi_q <= 1'b0;
      sel <= '0;
      tmr <= '0;
      hold <= '0;
      IN <= CODE_NONE;
      Invalid <= 1'b0;
      Timeout <= 1'b0;
      Cast <= '0;
    end else begin
      state <= state_n;
      ballot_q <= Ballot;
      multi_q <= multi;
      if (state == ARMED && state_n == DEBOUNCE) sel <= idx;
      tmr <= Ready ? tmr + TW'(1) : '0;
      hold <= (state == SEND) ? hold + HW'(1) : '0;
      IN <= (state == SEND) ? sel + CODE_W'(1) : CODE_NONE;
      Invalid <= inv_n;
      Timeout <= tmo_n;
      if (state_n == SEND && state != SEND && Cast != '1) Cast <= Cast + CAST_W'(1);
    end
  end
endmodule
